// File: rtl/bist_controller.sv
// BIST session controller: sequences seed/MISR clear, pattern generation,
// a settle cycle and a signature check, with sticky pass/fail results.
module bist_controller #(
  parameter int unsigned         SIG_W        = 4,
  parameter logic [SIG_W-1:0]    EXPECTED_SIG = SIG_W'(4'b1010),
  parameter int unsigned         CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0] misr_sig,
  output logic             session_clr,
  output logic             gen_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             busy_c;
  logic             last_pat_c;

  assign last_pat_c = (pat_cnt_q == (num_q - CNT_ONE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort wins over every busy-state transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_patterns != CNT_ZERO) ? S_CLEAR : S_DONE;
      S_CLEAR:  state_d = abort ? S_IDLE : S_RUN;
      S_RUN:    state_d = abort ? S_IDLE : (last_pat_c ? S_SETTLE : S_RUN);
      S_SETTLE: state_d = abort ? S_IDLE : S_CHECK;
      S_CHECK:  state_d = abort ? S_IDLE : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the state register only
  always_comb begin
    session_clr = 1'b0;
    gen_en      = 1'b0;
    busy_c      = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_CLEAR:  begin session_clr = 1'b1; busy_c = 1'b1; end
      S_RUN:    begin gen_en      = 1'b1; busy_c = 1'b1; end
      S_SETTLE: busy_c = 1'b1;
      S_CHECK:  busy_c = 1'b1;
      S_DONE:   done   = 1'b1;
      default:  ;
    endcase
    busy = busy_c;
  end

  // Next values for the pattern counter, latched count and sticky results
  always_comb begin
    pat_cnt_d = pat_cnt_q;
    num_d     = num_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        num_d     = num_patterns;
        pat_cnt_d = CNT_ZERO;
        pass_d    = 1'b0;
        fail_d    = (num_patterns == CNT_ZERO);
      end
    end else if (busy_c && abort) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if (state_q == S_RUN) begin
      pat_cnt_d = pat_cnt_q + CNT_ONE;
    end else if (state_q == S_CHECK) begin
      pass_d = (misr_sig == EXPECTED_SIG);
      fail_d = (misr_sig != EXPECTED_SIG);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_cnt_q <= CNT_ZERO;
      num_q     <= CNT_ZERO;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      pat_cnt_q <= pat_cnt_d;
      num_q     <= num_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign pass    = pass_q;
  assign fail    = fail_q;
  assign pat_cnt = pat_cnt_q;

endmodule

// File: tb/tb_bist_controller.sv
// Directed self-checking bench for bist_controller.
module tb_bist_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] num_patterns;
  logic [3:0] misr_sig;
  logic       session_clr;
  logic       gen_en;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic [7:0] pat_cnt;

  int checks;
  int failures;

  bist_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_patterns (num_patterns),
    .misr_sig     (misr_sig),
    .session_clr  (session_clr),
    .gen_en       (gen_en),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .pat_cnt      (pat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; num_patterns = 8'd0; misr_sig = 4'd0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({session_clr, gen_en, busy, done, pass, fail} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 000000", {session_clr, gen_en, busy, done, pass, fail});
    end
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (pat_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_pat_cnt: got %0d expected 0", pat_cnt);
    end
  endtask

  // N=4 session; start sampled at edge 0, done expected in cycle 8
  task automatic test_session(input logic [3:0] sig, input logic exp_pass);
    num_patterns = 8'd4; misr_sig = sig; start = 1'b1;
    tick(); // cycle 1
    start = 1'b0;
    checks++;
    if ({session_clr, gen_en, busy} !== 3'b101) begin
      failures++;
      $display("FAIL sess_clear_cycle: got clr/gen/busy=%b expected 101", {session_clr, gen_en, busy});
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      checks++;
      if ({session_clr, gen_en} !== 2'b01 || pat_cnt !== 8'(c - 2)) begin
        failures++;
        $display("FAIL sess_run_c%0d: got clr/gen=%b pat_cnt=%0d expected 01 %0d", c, {session_clr, gen_en}, pat_cnt, c - 2);
      end
    end
    tick(); // cycle 6 SETTLE
    checks++;
    if (gen_en !== 1'b0 || pat_cnt !== 8'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL sess_settle: got gen=%b pat_cnt=%0d busy=%b expected 0 4 1", gen_en, pat_cnt, busy);
    end
    tick(); // cycle 7 CHECK
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL sess_check: got done=%b busy=%b expected 0 1", done, busy);
    end
    tick(); // cycle 8 DONE
    checks++;
    if ({done, busy, pass, fail} !== {1'b1, 1'b0, exp_pass, ~exp_pass} || pat_cnt !== 8'd4) begin
      failures++;
      $display("FAIL sess_done: got done/busy/pass/fail=%b pat_cnt=%0d expected %b 4", {done, busy, pass, fail}, pat_cnt, {1'b1, 1'b0, exp_pass, ~exp_pass});
    end
    tick(); // cycle 9 IDLE
    checks++;
    if ({done, pass, fail} !== {1'b0, exp_pass, ~exp_pass}) begin
      failures++;
      $display("FAIL sess_hold: got done/pass/fail=%b expected %b", {done, pass, fail}, {1'b0, exp_pass, ~exp_pass});
    end
  endtask

  task automatic test_zero_patterns();
    num_patterns = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, pass, fail, gen_en, session_clr} !== 5'b10100) begin
      failures++;
      $display("FAIL zero_done: got done/pass/fail/gen/clr=%b expected 10100", {done, pass, fail, gen_en, session_clr});
    end
    tick();
    checks++;
    if ({done, fail, busy} !== 3'b010) begin
      failures++;
      $display("FAIL zero_after: got done/fail/busy=%b expected 010", {done, fail, busy});
    end
  endtask

  task automatic test_abort();
    int saw_done;
    int cyc;
    int gens;
    num_patterns = 8'd5; misr_sig = 4'b1010; start = 1'b1;
    tick(); start = 1'b0;      // CLEAR
    tick(); tick(); tick();    // RUN with pat_cnt 0,1,2
    checks++;
    if (pat_cnt !== 8'd2 || gen_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: got pat_cnt=%0d gen=%b expected 2 1", pat_cnt, gen_en);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({gen_en, busy, done, pass, fail} !== 5'b0) begin
      failures++;
      $display("FAIL abort_idle: got gen/busy/done/pass/fail=%b expected 00000", {gen_en, busy, done, pass, fail});
    end
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got activity=%0d expected 0", saw_done);
    end
    num_patterns = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    cyc = 1; gens = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (gen_en === 1'b1) gens++;
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 7 || gens !== 3 || pass !== 1'b1 || fail !== 1'b0 || pat_cnt !== 8'd3) begin
      failures++;
      $display("FAIL abort_restart: got done_cycle=%0d gens=%0d pass=%b fail=%b pat_cnt=%0d expected 7 3 1 0 3", cyc, gens, pass, fail, pat_cnt);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int clrs;
    int cyc;
    num_patterns = 8'd4; misr_sig = 4'b0110; start = 1'b1;
    tick(); start = 1'b0;   // cycle 1
    clrs = (session_clr === 1'b1) ? 1 : 0;
    checks++;
    if (pass !== 1'b0) begin
      failures++;
      $display("FAIL ign_clear_pass: got pass=%b expected 0", pass);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      start = (cyc == 3) ? 1'b1 : 1'b0;
      tick();
      cyc++;
      if (session_clr === 1'b1) clrs++;
    end
    start = 1'b0;
    checks++;
    if (cyc !== 8 || clrs !== 1 || fail !== 1'b1 || pass !== 1'b0) begin
      failures++;
      $display("FAIL ign_run_start: got done_cycle=%0d clrs=%0d pass=%b fail=%b expected 8 1 0 1", cyc, clrs, pass, fail);
    end
    start = 1'b1;           // pulse during DONE
    tick();
    start = 1'b0;
    checks++;
    if ({session_clr, busy, done, fail} !== 4'b0001) begin
      failures++;
      $display("FAIL ign_done_start: got clr/busy/done/fail=%b expected 0001", {session_clr, busy, done, fail});
    end
    tick(); tick();
    checks++;
    if ({session_clr, busy, fail, pass} !== 4'b0010) begin
      failures++;
      $display("FAIL ign_hold: got clr/busy/fail/pass=%b expected 0010", {session_clr, busy, fail, pass});
    end
  endtask

  task automatic test_async_reset();
    num_patterns = 8'd6; misr_sig = 4'b1010; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();  // RUN, pat_cnt=2
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({session_clr, gen_en, busy, done, pass, fail} !== 6'b0 || pat_cnt !== 8'd0) begin
      failures++;
      $display("FAIL async_rst: got outs=%b pat_cnt=%0d expected 000000 0", {session_clr, gen_en, busy, done, pass, fail}, pat_cnt);
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || pat_cnt !== 8'd0 || gen_en !== 1'b0) begin
      failures++;
      $display("FAIL async_release: got busy=%b pat_cnt=%0d gen=%b expected 0 0 0", busy, pat_cnt, gen_en);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_session(4'b1010, 1'b1);
    test_session(4'b0110, 1'b0);
    test_zero_patterns();
    test_abort();
    test_start_ignored();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter SIG_W, default 4: width of the MISR signature compared at end of session.
REQ-002 Parameter EXPECTED_SIG, default 4'b1010: golden signature that a passing session must produce.
REQ-003 Parameter CNT_W, default 8: width of the pattern-count configuration and of the pattern counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 start  input  1  session request; sampled only in IDLE.
REQ-007 abort  input  1  terminates an active session; ignored outside busy states.
REQ-008 num_patterns  input  CNT_W  number of patterns to apply; latched when start is accepted.
REQ-009 misr_sig  input  SIG_W  current MISR signature from the datapath.
REQ-010 session_clr  output  1  one-cycle clear pulse to the LFSR seed and the MISR.
REQ-011 gen_en  output  1  enable for LFSR and MISR; high exactly one cycle per applied pattern.
REQ-012 busy  output  1  high in CLEAR, RUN, SETTLE and CHECK.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 pass  output  1  sticky result: signature matched.
REQ-015 fail  output  1  sticky result: signature mismatch or illegal configuration.
REQ-016 pat_cnt  output  CNT_W  patterns applied so far in the current session.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, RUN, SETTLE, CHECK and DONE, encoded in registers; all outputs are registered or decoded from the state register only.
REQ-018 In IDLE, start=1 with num_patterns!=0 SHALL latch num_patterns, clear pass, fail and pat_cnt, and enter CLEAR.
REQ-019 In IDLE, start=1 with num_patterns==0 SHALL enter DONE directly with fail=1 and pass=0; gen_en and session_clr stay 0.
REQ-020 CLEAR SHALL last exactly one cycle: session_clr=1, gen_en=0; next state RUN.
REQ-021 RUN SHALL hold gen_en=1 and increment pat_cnt each cycle; when pat_cnt equals latched N-1, the next state is SETTLE, so gen_en is high for exactly N consecutive cycles.
REQ-022 On leaving RUN, pat_cnt SHALL equal N and hold that value until the next accepted start or reset.
REQ-023 SETTLE SHALL last one cycle with gen_en=0, so the final MISR update is stable before comparison.
REQ-024 CHECK SHALL compare misr_sig against EXPECTED_SIG and register pass=(equal) and fail=(not equal) on the CHECK->DONE edge; next state DONE.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; pass and fail remain held.
REQ-026 Latency: for a start sampled at edge k with N>0, RUN occupies cycles k+1+1 .. k+1+N, and done and pass/fail are visible in cycle k+N+4.
REQ-027 start SHALL be ignored in every state other than IDLE, including DONE; it does not queue.
REQ-028 abort=1 in any busy state SHALL force IDLE at the next edge, deassert gen_en from that edge, clear pass and fail, and never assert done.
REQ-029 abort SHALL take priority over the RUN->SETTLE and CHECK->DONE transitions in the same cycle; abort in IDLE or DONE has no effect.
REQ-030 pass and fail SHALL never both be 1.
REQ-031 session_clr and gen_en SHALL never both be 1.

Reset
REQ-032 While rst=1, without waiting for a clock edge: state=IDLE; session_clr, gen_en, busy, done, pass, fail and pat_cnt all 0; latched count = 0.
REQ-033 Reset asserted mid-session SHALL discard the session; after release, the block waits in IDLE for a new start.

Verification
REQ-034 num_patterns=4, start sampled at edge 0, misr_sig=4'b1010 in CHECK -> session_clr in cycle 1, gen_en in cycles 2-5, done in cycle 8, pass=1, fail=0, pat_cnt=4.
REQ-035 Same stimulus with misr_sig=4'b0110 -> done in cycle 8, pass=0, fail=1.
REQ-036 num_patterns=0 with start -> done in the next cycle, fail=1, gen_en and session_clr never asserted.
REQ-037 abort during RUN at pat_cnt=2 -> IDLE next cycle, gen_en=0, busy=0, done never pulses, pass=fail=0; a following start with N=3 completes normally.
REQ-038 start pulsed during RUN and during DONE -> no restart, no extra session_clr; pass/fail hold until the next start accepted in IDLE.
REQ-039 rst raised asynchronously between clock edges mid-RUN -> all outputs 0 immediately; pat_cnt=0 after release.
